// File: rtl/hrm_io_ctrl.sv
// Host I/O controller for the hrmcpu INBOX/OUTBOX: round-robin inbox arbiter and gapped outbox drain.
// Optional debug step control is enabled with `define HRM_IO_STEP_EN.
module hrm_io_ctrl #(
  parameter int DATA_W      = 8,
  parameter int OUT_POP_GAP = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              cpu_in_wr,
  input  logic              cpu_in_full,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_out_empty,
  output logic              cpu_out_rd,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              o_ready,
  input  logic              dbg_mode,
  input  logic              dbg_step,
  output logic              cpu_debug,
  output logic              cpu_nxtInstr
);

  typedef enum logic {O_IDLE, O_GAP} o_state_t;

  localparam logic [3:0] GAP_LD = 4'(OUT_POP_GAP);

  logic     grant_ok;
  logic     last_b;
  logic     a_acc;
  logic     b_acc;
  o_state_t o_state;
  o_state_t o_state_nxt;
  logic [3:0] gap_cnt;
  logic [3:0] gap_cnt_nxt;
  logic     pop;

  // Inbox arbitration: the cycle after a write is always blocked so a full flag
  // raised by that write is seen before the next grant.
  assign grant_ok = ~cpu_in_full & ~cpu_in_wr;
  assign a_ready  = grant_ok & a_valid & (~b_valid | last_b);
  assign b_ready  = grant_ok & b_valid & (~a_valid | ~last_b);
  assign a_acc    = a_valid & a_ready;
  assign b_acc    = b_valid & b_ready;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cpu_in_wr   <= 1'b0;
      cpu_in_data <= '0;
      last_b      <= 1'b1;
    end else begin
      cpu_in_wr <= a_acc | b_acc;
      if (a_acc) begin
        cpu_in_data <= a_data;
        last_b      <= 1'b0;
      end else if (b_acc) begin
        cpu_in_data <= b_data;
        last_b      <= 1'b1;
      end
    end
  end

  // Outbox drain FSM
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_state <= O_IDLE;
      gap_cnt <= '0;
    end else begin
      o_state <= o_state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    o_state_nxt = o_state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (o_state)
      O_IDLE: begin
        if (~cpu_out_empty && (~o_valid || o_ready)) begin
          pop         = 1'b1;
          gap_cnt_nxt = GAP_LD;
          o_state_nxt = O_GAP;
        end
      end
      O_GAP: begin
        gap_cnt_nxt = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) o_state_nxt = O_IDLE;
      end
      default: o_state_nxt = O_IDLE;
    endcase
  end

  // Output register: a pop in the same cycle as a handshake refills it.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cpu_out_rd <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
    end else begin
      cpu_out_rd <= pop;
      if (pop) begin
        o_data  <= cpu_out_data;
        o_valid <= 1'b1;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef HRM_IO_STEP_EN
  logic [2:0] step_sync;

  // Two-flop synchroniser plus one edge-detect flop; steps only pass in debug mode.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      step_sync    <= '0;
      cpu_debug    <= 1'b0;
      cpu_nxtInstr <= 1'b0;
    end else begin
      step_sync    <= {step_sync[1:0], dbg_step};
      cpu_debug    <= dbg_mode;
      cpu_nxtInstr <= step_sync[1] & ~step_sync[2] & cpu_debug;
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg   = dbg_mode ^ dbg_step;
  assign cpu_debug    = 1'b0;
  assign cpu_nxtInstr = 1'b0;
`endif

endmodule

// File: tb/tb_hrm_io_ctrl.sv
// Directed self-checking bench for hrm_io_ctrl: inbox arbitration, backpressure, outbox drain, reset.
module tb_hrm_io_ctrl;
  localparam int DATA_W = 8;
  localparam int GAP    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_in_wr, cpu_in_full;
  logic [DATA_W-1:0] cpu_out_data;
  logic              cpu_out_empty, cpu_out_rd;
  logic              o_valid, o_ready;
  logic [DATA_W-1:0] o_data;
  logic              dbg_mode, dbg_step, cpu_debug, cpu_nxtInstr;

  hrm_io_ctrl #(.DATA_W(DATA_W), .OUT_POP_GAP(GAP)) dut (
    .clk(clk), .i_rst(i_rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .cpu_in_data(cpu_in_data), .cpu_in_wr(cpu_in_wr), .cpu_in_full(cpu_in_full),
    .cpu_out_data(cpu_out_data), .cpu_out_empty(cpu_out_empty), .cpu_out_rd(cpu_out_rd),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .dbg_mode(dbg_mode), .dbg_step(dbg_step),
    .cpu_debug(cpu_debug), .cpu_nxtInstr(cpu_nxtInstr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // OUTBOX model: first-word-fall-through array, popped by cpu_out_rd
  logic [DATA_W-1:0] ob_mem [16];
  int ob_loaded = 0;
  int ob_pops   = 0;
  assign cpu_out_empty = (ob_loaded == ob_pops);
  assign cpu_out_data  = ob_mem[ob_pops % 16];

  logic [DATA_W-1:0] inbox_q [$];
  logic [DATA_W-1:0] rx_q [$];
  int   rd_count = 0, gap_run = 100, gap_err = 0, b2b_err = 0, full_err = 0, nx_count = 0;
  logic prev_wr = 1'b0;

  always @(posedge clk) begin
    prev_wr <= cpu_in_wr;
    if (cpu_in_wr) begin
      inbox_q.push_back(cpu_in_data);
      if (prev_wr) b2b_err <= b2b_err + 1;
      if (cpu_in_full) full_err <= full_err + 1;
    end
    if (cpu_out_rd) begin
      rd_count <= rd_count + 1;
      if (gap_run < GAP) gap_err <= gap_err + 1;
      gap_run <= 0;
      if (ob_loaded != ob_pops) ob_pops <= ob_pops + 1;
    end else if (gap_run < 100) begin
      gap_run <= gap_run + 1;
    end
    if (o_valid && o_ready) rx_q.push_back(o_data);
    if (cpu_nxtInstr) nx_count <= nx_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] av [2];
  logic [DATA_W-1:0] bv [2];
  int   ia, ib, dual;
  logic ga, gb;

  initial begin
    av = '{8'h11, 8'h12};
    bv = '{8'h21, 8'h22};
    i_rst = 1'b1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0;
    cpu_in_full = 0; o_ready = 0; dbg_mode = 0; dbg_step = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {30'd0, a_ready, b_ready}, 32'h0);
    chk("rst_inbox", {23'd0, cpu_in_wr, cpu_in_data}, 32'h0);
    chk("rst_outbox", {22'd0, cpu_out_rd, o_valid, o_data}, 32'h0);
    chk("rst_debug", {30'd0, cpu_debug, cpu_nxtInstr}, 32'h0);
    @(negedge clk); i_rst = 1'b0;

    // Single byte from A
    @(negedge clk); a_valid = 1; a_data = 8'h2A;
    #1; chk("single_a_ready", a_ready, 1); chk("single_b_ready", b_ready, 0);
    @(negedge clk); a_data = 8'h2B;
    #1; chk("single_wr", cpu_in_wr, 1); chk("single_data", cpu_in_data, 8'h2A);
    chk("single_gap_ready", a_ready, 0);
    @(negedge clk); a_valid = 0;
    #1; chk("single_wr_end", cpu_in_wr, 0);
    @(negedge clk);
    chk("single_count", inbox_q.size(), 1); chk("single_q0", inbox_q[0], 8'h2A);

    // Contention after reset: A favoured first, then alternate
    @(negedge clk); i_rst = 1;
    @(negedge clk); i_rst = 0;
    ia = 0; ib = 0; dual = 0;
    for (int cyc = 0; cyc < 40 && (ia < 2 || ib < 2); cyc++) begin
      @(negedge clk);
      a_valid = (ia < 2); a_data = (ia < 2) ? av[ia] : 8'h00;
      b_valid = (ib < 2); b_data = (ib < 2) ? bv[ib] : 8'h00;
      #1;
      ga = a_ready; gb = b_ready;
      if (ga && gb) dual++;
      @(posedge clk);
      if (ga) ia++;
      if (gb) ib++;
    end
    @(negedge clk); a_valid = 0; b_valid = 0;
    chk("cont_a_done", ia, 2); chk("cont_b_done", ib, 2); chk("cont_dual", dual, 0);
    repeat (2) @(negedge clk);
    chk("cont_count", inbox_q.size(), 5);
    chk("cont_q1", inbox_q[1], 8'h11); chk("cont_q2", inbox_q[2], 8'h21);
    chk("cont_q3", inbox_q[3], 8'h12); chk("cont_q4", inbox_q[4], 8'h22);

    // Backpressure: full for 10 cycles
    @(negedge clk); cpu_in_full = 1; a_valid = 1; a_data = 8'h33;
    for (int i = 0; i < 10; i++) begin
      #1; chk("bp_no_ready", a_ready, 0);
      @(negedge clk);
    end
    chk("bp_no_write", inbox_q.size(), 5);
    cpu_in_full = 0;
    #1; chk("bp_ready", a_ready, 1);
    @(negedge clk); a_valid = 0;
    #1; chk("bp_wr", cpu_in_wr, 1); chk("bp_data", cpu_in_data, 8'h33);
    repeat (2) @(negedge clk);
    chk("bp_count", inbox_q.size(), 6); chk("bp_q5", inbox_q[5], 8'h33);

    // Drain with consumer stalled, then released
    @(negedge clk); o_ready = 0;
    ob_mem[0] = 8'h05; ob_mem[1] = 8'h06; ob_loaded = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("drain_hold_vld", o_valid, 1); chk("drain_hold_data", o_data, 8'h05);
    end
    chk("drain_one_pop", rd_count, 1);
    o_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("drain_rx_n", rx_q.size(), 2);
    chk("drain_rx0", rx_q[0], 8'h05); chk("drain_rx1", rx_q[1], 8'h06);
    chk("drain_pops", rd_count, 2); chk("drain_vld_clr", o_valid, 0);

    // Streaming drain at full rate
    ob_mem[2] = 8'h07; ob_mem[3] = 8'h08; ob_mem[4] = 8'h09; ob_loaded = 5;
    repeat (10) @(negedge clk);
    chk("stream_rx_n", rx_q.size(), 5);
    chk("stream_rx2", rx_q[2], 8'h07); chk("stream_rx3", rx_q[3], 8'h08);
    chk("stream_rx4", rx_q[4], 8'h09); chk("stream_pops", rd_count, 5);
    chk("stream_gap", gap_err, 0);

    // Reset mid-operation: pending write and held byte discarded
    o_ready = 0; ob_mem[5] = 8'h44; ob_loaded = 6;
    repeat (2) @(negedge clk);
    #1; chk("rstm_held", {o_valid, o_data}, {1'b1, 8'h44});
    a_valid = 1; a_data = 8'h55;
    @(negedge clk); a_valid = 0;
    #1; chk("rstm_pending", cpu_in_wr, 1);
    i_rst = 1;
    #1;
    chk("rstm_inbox", {23'd0, cpu_in_wr, cpu_in_data}, 32'h0);
    chk("rstm_outbox", {22'd0, cpu_out_rd, o_valid, o_data}, 32'h0);
    @(negedge clk); i_rst = 0; b_valid = 1; b_data = 8'h66;
    #1; chk("rstm_b_ready", b_ready, 1); chk("rstm_a_ready", a_ready, 0);
    @(negedge clk); b_valid = 0;
    #1; chk("rstm_b_wr", {cpu_in_wr, cpu_in_data}, {1'b1, 8'h66});
    repeat (2) @(negedge clk);
    chk("rstm_count", inbox_q.size(), 7); chk("rstm_q6", inbox_q[6], 8'h66);

    // Debug run control
`ifdef HRM_IO_STEP_EN
    dbg_mode = 1;
    repeat (2) @(negedge clk);
    chk("dbg_mode_reg", cpu_debug, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dbg_step = 1;
      repeat (2) @(negedge clk); dbg_step = 0;
      repeat (4) @(negedge clk);
    end
    chk("dbg_three_steps", nx_count, 3);
    dbg_mode = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); dbg_step = 1;
      repeat (2) @(negedge clk); dbg_step = 0;
      repeat (4) @(negedge clk);
    end
    chk("dbg_dropped", nx_count, 3);
`else
    dbg_mode = 1; dbg_step = 1;
    repeat (4) @(negedge clk);
    chk("dbg_tied", {cpu_debug, cpu_nxtInstr}, 2'b00);
    dbg_step = 0;
    chk("dbg_no_steps", nx_count, 0);
`endif

    chk("inbox_back_to_back", b2b_err, 0);
    chk("inbox_write_full", full_err, 0);
    chk("outbox_gap", gap_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
